// File: rtl/shift_sub_divider_pkg.sv
// Shared widths and FSM state encoding for the 8-by-4 restoring divider.
package shift_sub_divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int STEPS      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
// Latency: 0 (pure combinational); no flow control.
module div_step
  import shift_sub_divider_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 shift_in,
  input  logic [DIVISOR_W-1:0] div,
  output logic                 qbit,
  output logic [DIVISOR_W-1:0] rem_next
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] t;

  // The partial remainder carries an implicit leading zero; t[4] is the sign of the trial.
  always_comb begin
    shifted  = {rem, shift_in};
    t        = shifted - {1'b0, div};
    qbit     = ~t[DIVISOR_W];
    rem_next = qbit ? t[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring shift/subtract divider, 8-bit dividend by 4-bit divisor, 4 edges START->READY.
// No backpressure: START is accepted every edge and restarts any division in flight.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
(
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  START,
  input  logic [DIVIDEND_W-1:0] P,
  input  logic [DIVISOR_W-1:0]  B,
  output logic [DIVISOR_W-1:0]  Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  READY,
  output logic                  OVF,
  output logic                  DIVZ
);

  localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic [DIVISOR_W-1:0] low_q, low_d;
  logic [DIVISOR_W-1:0] div_q, div_d;
  logic                 ovf_l_q, ovf_l_d;
  logic                 divz_l_q, divz_l_d;
  logic [DIVISOR_W-1:0] q_d, r_d;
  logic                 ovf_d, divz_d;

  logic                 step_qbit;
  logic [DIVISOR_W-1:0] step_rem;
  logic [DIVISOR_W-1:0] step_low;

  div_step u_step (
    .rem      (rem_q),
    .shift_in (low_q[DIVISOR_W-1]),
    .div      (div_q),
    .qbit     (step_qbit),
    .rem_next (step_rem)
  );

  assign step_low = {low_q[DIVISOR_W-2:0], step_qbit};
  assign READY    = (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    low_d    = low_q;
    div_d    = div_q;
    ovf_l_d  = ovf_l_q;
    divz_l_d = divz_l_q;
    q_d      = Q;
    r_d      = R;
    ovf_d    = OVF;
    divz_d   = DIVZ;

    if (START) begin
      state_d  = BUSY;
      cnt_d    = 3'd0;
      rem_d    = P[DIVIDEND_W-1:DIVISOR_W];
      low_d    = P[DIVISOR_W-1:0];
      div_d    = B;
      // A high nibble >= divisor means the quotient needs more than 4 bits; B==0 always lands here.
      ovf_l_d  = (P[DIVIDEND_W-1:DIVISOR_W] >= B);
      divz_l_d = (B == '0);
    end else if (state_q == BUSY) begin
      rem_d = step_rem;
      low_d = step_low;
      if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        q_d     = ovf_l_q ? '0 : step_low;
        r_d     = ovf_l_q ? '0 : step_rem;
        ovf_d   = ovf_l_q;
        divz_d  = divz_l_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      rem_q    <= '0;
      low_q    <= '0;
      div_q    <= '0;
      ovf_l_q  <= 1'b0;
      divz_l_q <= 1'b0;
      Q        <= '0;
      R        <= '0;
      OVF      <= 1'b0;
      DIVZ     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      div_q    <= div_d;
      ovf_l_q  <= ovf_l_d;
      divz_l_q <= divz_l_d;
      Q        <= q_d;
      R        <= r_d;
      OVF      <= ovf_d;
      DIVZ     <= divz_d;
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed table, restart/reset sequences, random vs. arithmetic model.
module tb_shift_sub_divider;

  logic       CK = 1'b0;
  logic       RN;
  logic       START;
  logic [7:0] P;
  logic [3:0] B;
  logic [3:0] Q, R;
  logic       READY, OVF, DIVZ;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] p;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       divz;
  } vec_t;

  vec_t vecs[9];

  shift_sub_divider dut (
    .CK    (CK),
    .RN    (RN),
    .START (START),
    .P     (P),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .READY (READY),
    .OVF   (OVF),
    .DIVZ  (DIVZ)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic run_and_check(input logic [7:0] p, input logic [3:0] b,
                               input logic [3:0] eq, input logic [3:0] er,
                               input logic eovf, input logic edivz, input string tag);
    int lat;
    START = 1'b1;
    P     = p;
    B     = b;
    tick();
    START = 1'b0;
    check({tag, " busy after load"}, 32'(READY), 32'd0);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (READY) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " Q"}, 32'(Q), 32'(eq));
    check({tag, " R"}, 32'(R), 32'(er));
    check({tag, " OVF"}, 32'(OVF), 32'(eovf));
    check({tag, " DIVZ"}, 32'(DIVZ), 32'(edivz));
  endtask

  // Reference: plain integer division; quotient must fit in 4 bits, else OVF with zeroed outputs.
  task automatic model_and_run(input logic [7:0] p, input logic [3:0] b, input string tag);
    int quo, rm;
    logic ovf, dz;
    dz = (b == 0);
    if (dz) begin
      ovf = 1'b1;
      quo = 0;
      rm  = 0;
    end else begin
      quo = int'(p) / int'(b);
      rm  = int'(p) % int'(b);
      ovf = (quo > 15);
      if (ovf) begin
        quo = 0;
        rm  = 0;
      end
    end
    run_and_check(p, b, 4'(quo), 4'(rm), ovf, dz, tag);
  endtask

  initial begin
    vecs[0] = '{8'd100, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0};
    vecs[1] = '{8'd119, 4'd8,  4'd14, 4'd7,  1'b0, 1'b0};
    vecs[2] = '{8'd0,   4'd5,  4'd0,  4'd0,  1'b0, 1'b0};
    vecs[3] = '{8'h50,  4'd5,  4'd0,  4'd0,  1'b1, 1'b0};
    vecs[4] = '{8'h12,  4'd0,  4'd0,  4'd0,  1'b1, 1'b1};
    vecs[5] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0};
    vecs[6] = '{8'd15,  4'd1,  4'd15, 4'd0,  1'b0, 1'b0};
    vecs[7] = '{8'd7,   4'd9,  4'd0,  4'd7,  1'b0, 1'b0};
    vecs[8] = '{8'd255, 4'd15, 4'd0,  4'd0,  1'b1, 1'b0};

    RN    = 1'b0;
    START = 1'b0;
    P     = '0;
    B     = '0;
    #12;
    check("reset READY", 32'(READY), 32'd1);
    check("reset Q", 32'(Q), 32'd0);
    check("reset R", 32'(R), 32'd0);
    check("reset OVF", 32'(OVF), 32'd0);
    check("reset DIVZ", 32'(DIVZ), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    tick();
    tick();
    check("idle after reset", 32'({READY, Q, R}), 32'({1'b1, 4'd0, 4'd0}));

    for (int i = 0; i < 9; i++)
      run_and_check(vecs[i].p, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].divz,
                    $sformatf("vec%0d", i));

    // Idle hold: outputs from the last vector must persist with START low.
    repeat (3) tick();
    check("idle hold", 32'({READY, Q, R, OVF, DIVZ}), 32'({1'b1, 4'd0, 4'd0, 1'b1, 1'b0}));

    // Restart mid-division; previous results 14/7 must hold until the new completion.
    run_and_check(8'd119, 4'd8, 4'd14, 4'd7, 1'b0, 1'b0, "pre-restart");
    START = 1'b1; P = 8'd100; B = 4'd7;
    tick();
    START = 1'b0;
    tick();
    tick();
    START = 1'b1; P = 8'd45; B = 4'd6;
    tick();
    START = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("restart busy %0d", i), 32'({READY, Q, R}), 32'({1'b0, 4'd14, 4'd7}));
    end
    tick();
    check("restart done", 32'({READY, Q, R, OVF, DIVZ}), 32'({1'b1, 4'd7, 4'd3, 1'b0, 1'b0}));

    // Asynchronous reset during step 2.
    START = 1'b1; P = 8'd100; B = 4'd7;
    tick();
    START = 1'b0;
    tick();
    #2;
    RN = 1'b0;
    #1;
    check("async reset READY", 32'(READY), 32'd1);
    check("async reset Q/R", 32'({Q, R}), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post-reset stays idle", 32'({READY, Q, R, OVF}), 32'({1'b1, 4'd0, 4'd0, 1'b0}));
    end

    for (int i = 0; i < 1000; i++) begin
      logic [3:0] b, hi, lo;
      b  = 4'($urandom_range(1, 15));
      hi = 4'($urandom_range(0, int'(b) - 1));
      lo = 4'($urandom_range(0, 15));
      model_and_run({hi, lo}, b, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 200; i++)
      model_and_run(8'($urandom), 4'($urandom), $sformatf("any%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
